// File: rtl/rfft_ctrl_p.sv
// rfft_ctrl_p: stage/address sequencer for an in-place radix-2 real FFT.
// Walks NSTG stages. Each stage streams 2^AW butterfly reads, then waits
// PE_LAT cycles so the butterfly pipeline can drain its writes. An external
// load mode overrides every address and write strobe.
module rfft_ctrl_p #(
    parameter  int LOG2N  = 8,
    parameter  int PE_LAT = 2,
    localparam int AW     = LOG2N - 2,
    localparam int NSTG   = LOG2N - 1,
    localparam int SW     = $clog2(NSTG)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          load_i,
    input  logic [AW-1:0] ext_addr_i,
    input  logic          ext_we_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [SW-1:0] stage_o,
    output logic [AW-1:0] rd_addr0_o,
    output logic [AW-1:0] rd_addr1_o,
    output logic [AW-1:0] wr_addr0_o,
    output logic [AW-1:0] wr_addr1_o,
    output logic          we_o,
    output logic [AW-1:0] tf_addr_o,
    output logic          rd_swap_o,
    output logic          wr_swap_o,
    output logic          bypass_n_o
);

    localparam int DW = $clog2(PE_LAT + 1);
    localparam logic [AW-1:0] CNT_MAX  = {AW{1'b1}};
    localparam logic [SW-1:0] LAST_STG = SW'(NSTG - 1);
    localparam logic [DW-1:0] DRN_LAST = DW'(PE_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic [DW-1:0] dcnt_q,  dcnt_d;

    // Delay line matching the butterfly pipeline: valid flag and read index.
    logic          vld_q     [PE_LAT];
    logic [AW-1:0] dly_cnt_q [PE_LAT];

    // Partner address: invert the top 'stage' bits of the index.
    function automatic logic [AW-1:0] inv_top(input logic [AW-1:0] a,
                                              input logic [SW-1:0] s);
        logic [AW-1:0] r;
        r = a;
        for (int i = 0; i < AW; i++)
            if (i >= AW - int'(s)) r[i] = ~a[i];
        return r;
    endfunction

    // Sequencer state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Next-state logic: load aborts, otherwise READ/DRAIN per stage.
    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        if (load_i) begin
            state_d = S_IDLE;
            stage_d = '0;
            cnt_d   = '0;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_d = S_READ;
                        stage_d = '0;
                        cnt_d   = '0;
                    end
                end
                S_READ: begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = S_DRAIN;
                        dcnt_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (dcnt_q == DRN_LAST) begin
                        if (stage_q != LAST_STG) begin
                            state_d = S_READ;
                            stage_d = stage_q + 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Valid/index delay line; flushed by load so aborted reads never write.
    // NOTE: this small array is reset on purpose; a stale valid bit after
    // reset would fire a spurious bank write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PE_LAT; i++) begin
                vld_q[i]     <= 1'b0;
                dly_cnt_q[i] <= '0;
            end
        end else if (load_i) begin
            for (int i = 0; i < PE_LAT; i++) begin
                vld_q[i]     <= 1'b0;
                dly_cnt_q[i] <= '0;
            end
        end else begin
            vld_q[0]     <= (state_q == S_READ);
            dly_cnt_q[0] <= cnt_q;
            for (int i = 1; i < PE_LAT; i++) begin
                vld_q[i]     <= vld_q[i-1];
                dly_cnt_q[i] <= dly_cnt_q[i-1];
            end
        end
    end

    // Address, swap and strobe outputs; load mode overrides combinationally.
    always_comb begin
        busy_o     = ((state_q == S_READ) || (state_q == S_DRAIN)) && !load_i;
        done_o     = (state_q == S_DONE);
        stage_o    = stage_q;
        bypass_n_o = (stage_q != LAST_STG);
        rd_addr0_o = '0;
        rd_addr1_o = '0;
        tf_addr_o  = '0;
        rd_swap_o  = 1'b0;
        wr_swap_o  = 1'b0;
        wr_addr0_o = dly_cnt_q[PE_LAT-1];
        wr_addr1_o = inv_top(dly_cnt_q[PE_LAT-1], stage_q);
        we_o       = vld_q[PE_LAT-1];
        if (state_q == S_READ) begin
            rd_addr0_o = cnt_q;
            rd_addr1_o = inv_top(cnt_q, stage_q);
            if (stage_q != LAST_STG) tf_addr_o = cnt_q << stage_q;
            for (int i = 0; i < AW; i++)
                if (i == AW - int'(stage_q)) rd_swap_o = cnt_q[i];
        end
        for (int i = 0; i < AW; i++)
            if (i == AW - 1 - int'(stage_q)) wr_swap_o = dly_cnt_q[PE_LAT-1][i];
        if (load_i) begin
            rd_addr0_o = ext_addr_i;
            rd_addr1_o = ext_addr_i;
            wr_addr0_o = ext_addr_i;
            wr_addr1_o = ext_addr_i;
            tf_addr_o  = ext_addr_i;
            we_o       = ext_we_i;
            rd_swap_o  = 1'b0;
            wr_swap_o  = 1'b0;
        end
    end

endmodule

// File: tb/tb_rfft_ctrl_p.sv
// Directed testbench for rfft_ctrl_p: a LOG2N=4/PE_LAT=2 instance for
// detailed address checks and a LOG2N=8/PE_LAT=3 instance for run length.
module tb_rfft_ctrl_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, load, ext_we, start_b;
    logic [1:0] ext_addr;

    logic       busy, done, we, rsw, wsw, byp;
    logic [1:0] stage, rd0, rd1, wr0, wr1, tf;

    logic       busy_b, done_b, we_b, rsw_b, wsw_b, byp_b;
    logic [2:0] stage_b;
    logic [5:0] rd0_b, rd1_b, wr0_b, wr1_b, tf_b;

    int tests = 0;
    int fails = 0;

    rfft_ctrl_p #(.LOG2N(4), .PE_LAT(2)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .load_i(load),
        .ext_addr_i(ext_addr), .ext_we_i(ext_we),
        .busy_o(busy), .done_o(done), .stage_o(stage),
        .rd_addr0_o(rd0), .rd_addr1_o(rd1), .wr_addr0_o(wr0), .wr_addr1_o(wr1),
        .we_o(we), .tf_addr_o(tf), .rd_swap_o(rsw), .wr_swap_o(wsw),
        .bypass_n_o(byp)
    );

    rfft_ctrl_p #(.LOG2N(8), .PE_LAT(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .load_i(1'b0),
        .ext_addr_i(6'd0), .ext_we_i(1'b0),
        .busy_o(busy_b), .done_o(done_b), .stage_o(stage_b),
        .rd_addr0_o(rd0_b), .rd_addr1_o(rd1_b), .wr_addr0_o(wr0_b),
        .wr_addr1_o(wr1_b), .we_o(we_b), .tf_addr_o(tf_b), .rd_swap_o(rsw_b),
        .wr_swap_o(wsw_b), .bypass_n_o(byp_b)
    );

    // Hand-computed tables for LOG2N=4 (AW=2).
    int rd1_s1 [4] = '{2, 3, 0, 1};
    int tf_s1  [4] = '{0, 2, 0, 2};
    int rsw_s1 [4] = '{0, 0, 1, 1};
    int wr1_s1 [4] = '{2, 3, 0, 1};
    int wsw_s1 [4] = '{0, 1, 0, 1};
    int rd1_s2 [4] = '{3, 2, 1, 0};

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then walk interval i (after the i-th edge) until done.
    task automatic run_small(input bit detail, output int busy_n,
                             output int we_n, output int done_at);
        busy_n  = 0;
        we_n    = 0;
        done_at = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 60 && done_at < 0; i++) begin
            if (done) begin
                done_at = i;
            end else begin
                if (busy) busy_n++;
                if (we) we_n++;
                if (detail) begin
                    if (i >= 3 && i <= 6) check("s0_wr_addr0", int'(wr0), i - 3);
                    if (i == 7) check("s1_stage", int'(stage), 1);
                    if (i >= 7 && i <= 10) begin
                        check("s1_rd_addr1", int'(rd1), rd1_s1[i-7]);
                        check("s1_tf_addr", int'(tf), tf_s1[i-7]);
                        check("s1_rd_swap", int'(rsw), rsw_s1[i-7]);
                        check("s1_bypass_n", int'(byp), 1);
                    end
                    if (i >= 9 && i <= 12) begin
                        check("s1_wr_addr1", int'(wr1), wr1_s1[i-9]);
                        check("s1_wr_swap", int'(wsw), wsw_s1[i-9]);
                    end
                    if (i >= 13 && i <= 16) begin
                        check("s2_rd_addr1", int'(rd1), rd1_s2[i-13]);
                        check("s2_bypass_n", int'(byp), 0);
                        check("s2_tf_addr", int'(tf), 0);
                    end
                    if (i >= 15 && i <= 18) begin
                        check("s2_we", int'(we), 1);
                        check("s2_wr_swap", int'(wsw), 0);
                    end
                end
                tick();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bn, wn, da, cnt_we, cnt_busy;
        rst = 1'b1; start = 1'b0; load = 1'b0; ext_we = 1'b0;
        ext_addr = 2'd0; start_b = 1'b0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(we), 0);
        check("rst_stage", int'(stage), 0);
        check("rst_rd_addr0", int'(rd0), 0);
        tick();
        rst = 1'b0;
        tick();

        // Start and Load together: Load wins, sequencer stays idle.
        start = 1'b1; load = 1'b1;
        tick();
        start = 1'b0; load = 1'b0;
        check("start_load_busy", int'(busy), 0);
        tick();
        check("start_load_busy_next", int'(busy), 0);

        // Full run with per-cycle address checks.
        run_small(1'b1, bn, wn, da);
        check("run1_busy_cycles", bn, 18);
        check("run1_we_cycles", wn, 12);
        check("run1_done_interval", da, 19);

        // Done is a held level.
        tick(); tick(); tick();
        check("done_held", int'(done), 1);
        check("done_busy", int'(busy), 0);
        check("done_we", int'(we), 0);

        // Start from DONE restarts at stage 0 and clears done on that edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done", int'(done), 0);
        check("restart_busy", int'(busy), 1);
        check("restart_stage", int'(stage), 0);
        check("restart_rd_addr0", int'(rd0), 0);
        for (int k = 0; k < 7; k++) tick();
        check("pre_load_stage", int'(stage), 1);

        // Load mid stage-1 READ: combinational override, then idle.
        load = 1'b1; ext_addr = 2'd2; ext_we = 1'b1;
        #1;
        check("load_busy_comb", int'(busy), 0);
        check("load_rd_addr0", int'(rd0), 2);
        check("load_wr_addr1", int'(wr1), 2);
        check("load_we_comb", int'(we), 1);
        tick();
        check("load_rd_addr1", int'(rd1), 2);
        check("load_wr_addr0", int'(wr0), 2);
        check("load_tf_addr", int'(tf), 2);
        check("load_we", int'(we), 1);
        check("load_done", int'(done), 0);
        check("load_busy", int'(busy), 0);
        load = 1'b0; ext_we = 1'b0; ext_addr = 2'd0;
        cnt_we = 0; cnt_busy = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (we) cnt_we++;
            if (busy) cnt_busy++;
        end
        check("post_load_we", cnt_we, 0);
        check("post_load_busy", cnt_busy, 0);

        // Reset during stage-0 DRAIN.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("drain_we_before_rst", int'(we), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_we", int'(we), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_stage", int'(stage), 0);
        tick();
        rst = 1'b0;
        tick();
        run_small(1'b0, bn, wn, da);
        check("run2_busy_cycles", bn, 18);
        check("run2_we_cycles", wn, 12);
        check("run2_done_interval", da, 19);

        // Large instance: 7 stages of 64+3 cycles, extra start ignored.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        bn = 0; wn = 0; da = -1;
        for (int i = 1; i <= 1000 && da < 0; i++) begin
            if (done_b) begin
                da = i;
            end else begin
                if (busy_b) bn++;
                if (we_b) wn++;
                start_b = (i == 10);
                tick();
            end
        end
        start_b = 1'b0;
        check("big_busy_cycles", bn, 469);
        check("big_we_cycles", wn, 448);
        check("big_done_interval", da, 470);
        check("big_final_stage", int'(stage_b), 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rfft_ctrl_p.md
RFFT_CTRL_P -- requirements
Module: rfft_ctrl_p

Interface
REQ-001 Parameter LOG2N, default 8: log2 of transform points; legal 4..12.
REQ-002 Parameter PE_LAT, default 2: butterfly pipeline latency in cycles; legal 1..8.
REQ-003 Derived: AW = LOG2N-2 (bank address width); NSTG = LOG2N-1 (stage count); SW = ceil(log2(NSTG)).
REQ-004 Clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 Start  in  1  request to run one transform; sampled in IDLE only.
REQ-007 Load  in  1  external load mode; overrides and aborts sequencing.
REQ-008 Ext_addr  in  AW  external bank/twiddle address during Load.
REQ-009 Ext_we  in  1  external write enable during Load.
REQ-010 Busy  out  1  high in READ or DRAIN.
REQ-011 Done  out  1  transform complete; level, held until Start or Load.
REQ-012 Stage  out  SW  current stage index.
REQ-013 Rd_addr0, Rd_addr1  out  AW each  read addresses for bank pairs 0/1.
REQ-014 Wr_addr0, Wr_addr1  out  AW each  write addresses for bank pairs 0/1.
REQ-015 We  out  1  bank write enable.
REQ-016 Tf_addr  out  AW  twiddle ROM address.
REQ-017 Rd_swap, Wr_swap  out  1 each  PE input / RAM input crossbar selects.
REQ-018 Bypass_n  out  1  low during the final stage (twiddle multiply bypassed).

Function
REQ-019 States: IDLE, READ, DRAIN, DONE; reset state IDLE.
REQ-020 IDLE->READ on Start=1 with Load=0; Stage and read counter cnt cleared to 0.
REQ-021 READ: cnt increments 0..2^AW-1, one address per cycle; at cnt=2^AW-1 -> DRAIN.
REQ-022 DRAIN: lasts exactly PE_LAT cycles; then Stage<NSTG-1 -> Stage+1, cnt=0, READ; else -> DONE.
REQ-023 Per-stage length = 2^AW+PE_LAT cycles; total Start-to-Done = NSTG*(2^AW+PE_LAT) cycles.
REQ-024 DONE: Done=1; Start=1 -> READ with Stage=0, Done cleared same edge.
REQ-025 Rd_addr0 = cnt in READ; 0 otherwise (outside Load).
REQ-026 Rd_addr1 = cnt with top Stage bits inverted (Stage 0 none, Stage NSTG-1 all AW bits).
REQ-027 Tf_addr = cnt[AW-1-Stage:0] shifted left by Stage, zero-filled; 0 in final stage and outside READ.
REQ-028 Rd_swap = 0 in Stage 0; = cnt[AW-Stage] for Stage>=1 in READ; 0 otherwise.
REQ-029 Valid pipeline: PE_LAT-deep shift of (state==READ) and cnt; We = delayed valid.
REQ-030 Wr_addr0/Wr_addr1 = delayed cnt with same inversion rule as REQ-026, using Stage.
REQ-031 Wr_swap = delayed cnt[AW-1-Stage] for Stage<NSTG-1; 0 in final stage.
REQ-032 All writes of a stage complete before Stage increments; no write occurs in IDLE or DONE outside Load.
REQ-033 Bypass_n = 0 when Stage = NSTG-1, else 1.
REQ-034 Load=1: next state IDLE, Done cleared, valid pipeline flushed; Rd_addr*, Wr_addr*, Tf_addr = Ext_addr combinationally; We = Ext_we; Busy=0.
REQ-035 Load asserted mid-READ/DRAIN aborts transform; no further sequencer writes occur.
REQ-036 Start while Busy ignored; Start and Load together: Load wins.

Reset
REQ-037 Reset=1 forces immediately: state IDLE, Stage=0, cnt=0, valid pipeline cleared, Done=0, Busy=0, We=0.
REQ-038 Reset mid-transform discards all progress; next Start after release begins at Stage 0.

Verification
REQ-039 LOG2N=4, PE_LAT=2, Start pulse -> Busy 18 cycles, Done rises on 18th edge, exactly 12 We cycles.
REQ-040 LOG2N=4, Stage 1 READ cnt=0..3 -> Rd_addr1 = 2,3,0,1; Tf_addr = 0,2,0,2; Rd_swap = 0,0,1,1.
REQ-041 LOG2N=4, Stage 2 -> Rd_addr1 = 3,2,1,0; Bypass_n=0; Tf_addr=0; Wr_swap=0.
REQ-042 Load=1 during Stage 1 READ, Ext_addr=2, Ext_we=1 -> next cycle IDLE, all addresses 2, We=1, Done=0.
REQ-043 Reset pulse in DRAIN of Stage 0 -> We=0 immediately; Start after release gives full 18-cycle run.
REQ-044 LOG2N=8, PE_LAT=3 default-scale run -> Done after 7*67=469 cycles; Start during Busy has no effect.
